multi_timer: RTL and testbench

Parametrised multi-channel programmable timer for the single-cycle CPU's I/O subsystem. It is the successor to the single-channel timer currently driven from an output port. It provides NCH independent down-counters, each with one-shot or periodic mode. Each channel has a sticky interrupt-pending bit that feeds one CPU interrupt line (pInt*) and is cleared by an acknowledge. Software programs the block through a small register file written from CPU output-port logic.

---
 rtl/multi_timer_pkg.sv | 16 +
 rtl/multi_timer_ch.sv | 80 ++++++++
 rtl/multi_timer.sv | 96 +++++++++
 tb/tb_multi_timer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register offsets and CTRL bit positions shared by the
// multi-channel timer and its per-channel sub-module.
package multi_timer_pkg;

  // Register offsets within one channel's address window
  localparam logic [1:0] REG_LOAD_LO = 2'd0;
  localparam logic [1:0] REG_LOAD_HI = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_PRESC   = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_PSC = 2;

endpackage

// File: rtl/multi_timer_ch.sv
// multi_timer_ch: one timer channel. Holds the reload register, CTRL, the
// down-counter and the sticky interrupt-pending flag.
module multi_timer_ch
  import multi_timer_pkg::*;
#(
  parameter int CW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we_lo,
  input  logic          i_we_hi,
  input  logic          i_we_ctrl,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_strobe,
  input  logic          i_ack,
  output logic [CW-1:0] o_count,
  output logic [2:0]    o_ctrl,
  output logic          o_irq
);

  logic [CW-1:0] r_reload;
  logic [CW-1:0] r_count;
  logic [2:0]    r_ctrl;
  logic          r_irq;
  logic          w_tick;
  logic          w_start;
  logic          w_expire;

  // A PSC channel advances only on the shared prescaler strobe
  assign w_tick   = r_ctrl[CTRL_PSC] ? i_strobe : 1'b1;
  // Only an EN 0->1 transition reloads; rewriting EN=1 keeps counting
  assign w_start  = i_we_ctrl & i_wdata[CTRL_EN] & ~r_ctrl[CTRL_EN];
  assign w_expire = ~w_start & r_ctrl[CTRL_EN] & w_tick & (r_count == '0);

  // Reload register: new values are picked up at the next reload only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reload <= '0;
    end else begin
      if (i_we_lo) r_reload[DW-1:0]  <= i_wdata;
      if (i_we_hi) r_reload[CW-1:DW] <= i_wdata[CW-DW-1:0];
    end
  end

  // CTRL register; a one-shot expiry drops EN unless software writes CTRL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= '0;
    end else if (i_we_ctrl) begin
      r_ctrl <= i_wdata[2:0];
    end else if (w_expire && !r_ctrl[CTRL_PER]) begin
      r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // Down-counter: load on enable, decrement per tick, reload or hold at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= r_reload;
    end else if (r_ctrl[CTRL_EN] && w_tick) begin
      if (r_count != '0)          r_count <= r_count - CW'(1);
      else if (r_ctrl[CTRL_PER])  r_count <= r_reload;
    end
  end

  // Sticky pending flag; expiry beats a simultaneous acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_irq <= 1'b0;
    else if (w_expire) r_irq <= 1'b1;
    else if (i_ack)    r_irq <= 1'b0;
  end

  assign o_count = r_count;
  assign o_ctrl  = r_ctrl;
  assign o_irq   = r_irq;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NCH-channel programmable down-counter timer with per-channel
// sticky interrupts. Address = {channel, reg}. Optional shared prescaler is
// built when MULTI_TIMER_PRESCALER_EN is defined.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int DW  = 8,
  parameter int AW  = $clog2(NCH) + 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata,
  input  logic [NCH-1:0] ack,
  output logic [NCH-1:0] irq
);

  logic [AW-1:0] w_ch;
  logic [1:0]    w_reg;
  logic          w_strobe;
  logic [DW-1:0] w_presc_rd;
  logic [CW-1:0] w_count [NCH];
  logic [2:0]    w_ctrl  [NCH];

  assign w_ch  = addr >> 2;
  assign w_reg = addr[1:0];

`ifdef MULTI_TIMER_PRESCALER_EN
  logic [DW-1:0] r_presc;
  logic [DW-1:0] r_psc_cnt;

  assign w_strobe   = (r_psc_cnt == r_presc);
  assign w_presc_rd = r_presc;

  // Shared prescaler: one strobe every PRESC+1 clocks, restarted by a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_psc_cnt <= '0;
    end else if (we && w_reg == REG_PRESC) begin
      r_presc   <= wdata;
      r_psc_cnt <= '0;
    end else if (w_strobe) begin
      r_psc_cnt <= '0;
    end else begin
      r_psc_cnt <= r_psc_cnt + DW'(1);
    end
  end
`else
  assign w_strobe   = 1'b1;
  assign w_presc_rd = '0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic w_sel;
    assign w_sel = we && (w_ch == AW'(g));

    multi_timer_ch #(.CW(CW), .DW(DW)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_we_lo   (w_sel && w_reg == REG_LOAD_LO),
      .i_we_hi   (w_sel && w_reg == REG_LOAD_HI),
      .i_we_ctrl (w_sel && w_reg == REG_CTRL),
      .i_wdata   (wdata),
      .i_strobe  (w_strobe),
      .i_ack     (ack[g]),
      .o_count   (w_count[g]),
      .o_ctrl    (w_ctrl[g]),
      .o_irq     (irq[g])
    );
  end

  // Readback mux; PRESC is shared so its channel field is ignored
  always_comb begin
    logic [2*DW-1:0] v_ext;
    rdata = '0;
    v_ext = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_ch == AW'(i)) begin
        v_ext[CW-1:0] = w_count[i];
        case (w_reg)
          REG_LOAD_LO: rdata = v_ext[DW-1:0];
          REG_LOAD_HI: rdata = v_ext[2*DW-1:DW];
          REG_CTRL:    rdata = DW'({irq[i], w_ctrl[i]});
          default:     rdata = '0;
        endcase
      end
    end
    if (w_reg == REG_PRESC) rdata = w_presc_rd;
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed test of multi_timer (NCH=4, CW=16, DW=8).
module tb_multi_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [3:0] ack;
  logic [3:0] irq;

  int total = 0;
  int bad   = 0;

  multi_timer #(.NCH(4), .CW(16), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called in the low phase; the write lands on the next rising edge
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // One-cycle ack, then count clocks until the flag rises again
  task automatic ack_gap(input int ch, output int n);
    ack[ch] = 1'b1;
    @(negedge clk);
    ack[ch] = 1'b0;
    n = 1;
    chk($sformatf("ack_clr%0d", ch), irq[ch], 1'b0);
    while (!irq[ch] && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [7:0] v;
    int n;
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; ack = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: everything reads zero
    repeat (20) @(negedge clk);
    chk("rst_irq", irq, 4'h0);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd(a[3:0], v);
      chk($sformatf("rst_rd%0d", a), v, 8'h00);
    end

    // Ch0 periodic, reload 4: count 4,3,2,1,0 then expire
    wr(4'd0, 8'd4);
    wr(4'd1, 8'd0);
    wr(4'd2, 8'd3);
    rd(4'd0, v);
    chk("ch0_load", v, 8'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        rd(4'd0, v);
        chk($sformatf("ch0_cnt%0d", k), v, 8'(4 - k));
      end
      chk($sformatf("ch0_irq%0d", k), irq[0], (k == 5) ? 1'b1 : 1'b0);
    end
    rd(4'd2, v);
    chk("ch0_ctrl", v, 8'h0B);
    ack_gap(0, n);
    chk("ch0_gap", n, 5);
    wr(4'd2, 8'd0);
    ack[0] = 1'b1; @(negedge clk); ack[0] = 1'b0;
    chk("ch0_off", irq[0], 1'b0);

    // Ch1 one-shot, reload 2
    wr(4'd4, 8'd2);
    wr(4'd6, 8'd1);
    repeat (2) @(negedge clk);
    chk("ch1_pre", irq[1], 1'b0);
    @(negedge clk);
    chk("ch1_exp", irq[1], 1'b1);
    rd(4'd6, v);
    chk("ch1_ctrl", v, 8'h08);
    rd(4'd4, v);
    chk("ch1_cnt", v, 8'd0);
    ack[1] = 1'b1; @(negedge clk); ack[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("ch1_quiet", irq[1], 1'b0);
    rd(4'd6, v);
    chk("ch1_ctrl2", v, 8'h00);
    rd(4'd5, v);
    chk("ch1_hi", v, 8'h00);

    // Ch2 periodic reload 0 with ack held: set wins every cycle
    wr(4'd8, 8'd0);
    ack[2] = 1'b1;
    wr(4'd10, 8'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("ch2_hold%0d", k), irq[2], 1'b1);
    end
    ack[2] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ch2_rel", irq[2], 1'b1);
    end
    wr(4'd10, 8'd0);
    ack[2] = 1'b1; @(negedge clk); ack[2] = 1'b0;
    chk("ch2_off", irq[2], 1'b0);

    // Ch3 reload 1, CTRL=7, PRESC=3 (shared register, written via ch0 window)
    wr(4'd12, 8'd1);
    wr(4'd13, 8'd0);
    wr(4'd3, 8'd3);
    rd(4'd15, v);
`ifdef MULTI_TIMER_PRESCALER_EN
    chk("presc_rd", v, 8'd3);
`else
    chk("presc_rd", v, 8'd0);
`endif
    wr(4'd14, 8'd7);
    n = 0;
    while (!irq[3] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ch3_first", (n < 60) ? 1 : 0, 1);
    ack_gap(3, n);
`ifdef MULTI_TIMER_PRESCALER_EN
    chk("ch3_gap", n, 8);
`else
    chk("ch3_gap", n, 2);
`endif

    // Reset mid-count on ch0 (reload 5, count observed at 2)
    wr(4'd0, 8'd5);
    wr(4'd2, 8'd3);
    repeat (3) @(negedge clk);
    rd(4'd0, v);
    chk("rc_cnt", v, 8'd2);
    reset = 1'b1;
    rd(4'd0, v);
    chk("rc_clr", v, 8'd0);
    chk("rc_irq", irq, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rc_quiet", irq, 4'h0);
    rd(4'd0, v);
    chk("rc_cnt2", v, 8'd0);
    rd(4'd2, v);
    chk("rc_ctrl", v, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
